// File: rtl/mux_column_scheduler.sv
// Round-robin scheduler that time-multiplexes one physical macro column among
// NUM_COLS virtual columns. Optional LEARN phase enabled by MUX_SCHED_LEARN_EN.
module mux_column_scheduler #(
  parameter int NUM_COLS    = 4,
  parameter int GAMMA_LEN   = 8,
  parameter int GRST_CYCLES = 2,
`ifdef MUX_SCHED_LEARN_EN
  parameter int LEARN_CYCLES = 2,
`endif
  parameter int IDX_W       = $clog2(NUM_COLS),
  parameter int STEP_W      = $clog2(GAMMA_LEN)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic [NUM_COLS-1:0] i_req,
  output logic [NUM_COLS-1:0] o_grant,
  output logic [IDX_W-1:0]    o_grant_idx,
  output logic                o_col_load,
  output logic                o_start_count,
  output logic [STEP_W-1:0]   o_step,
  output logic                o_grst,
  output logic                o_done,
`ifdef MUX_SCHED_LEARN_EN
  output logic                o_learn_en,
`endif
  output logic                o_busy
);

  localparam int GC_W = (GRST_CYCLES > 1) ? $clog2(GRST_CYCLES) : 1;
`ifdef MUX_SCHED_LEARN_EN
  localparam int LC_W = (LEARN_CYCLES > 1) ? $clog2(LEARN_CYCLES) : 1;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
`ifdef MUX_SCHED_LEARN_EN
    S_LEARN,
`endif
    S_GRST
  } state_t;

  state_t                r_state;
  logic [NUM_COLS-1:0]   r_grant;
  logic [IDX_W-1:0]      r_grant_idx;
  logic [IDX_W-1:0]      r_ptr;
  logic                  r_col_load;
  logic                  r_start_count;
  logic [STEP_W-1:0]     r_step;
  logic                  r_grst;
  logic                  r_done;
  logic                  r_busy;
  logic [GC_W-1:0]       r_gcnt;
`ifdef MUX_SCHED_LEARN_EN
  logic                  r_learn_en;
  logic [LC_W-1:0]       r_lcnt;
`endif

  logic                  w_any;
  logic [IDX_W-1:0]      w_win;
  int                    w_j;

  // First requester strictly after the pointer, wrapping around.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_j   = 0;
    for (int k = 0; k < NUM_COLS; k++) begin
      w_j = int'(r_ptr) + k + 1;
      if (w_j >= NUM_COLS) w_j = w_j - NUM_COLS;
      if (!w_any && i_req[w_j[IDX_W-1:0]]) begin
        w_any = 1'b1;
        w_win = w_j[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_grant_idx   <= '0;
      r_ptr         <= IDX_W'(NUM_COLS - 1);
      r_col_load    <= 1'b0;
      r_start_count <= 1'b0;
      r_step        <= '0;
      r_grst        <= 1'b0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
      r_gcnt        <= '0;
`ifdef MUX_SCHED_LEARN_EN
      r_learn_en    <= 1'b0;
      r_lcnt        <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_en && w_any) begin
            r_state     <= S_LOAD;
            r_grant     <= NUM_COLS'(1) << w_win;
            r_grant_idx <= w_win;
            r_ptr       <= w_win;
            r_col_load  <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_LOAD: begin
          r_state       <= S_RUN;
          r_col_load    <= 1'b0;
          r_start_count <= 1'b1;
          r_step        <= '0;
        end
        S_RUN: begin
          if (r_step == STEP_W'(GAMMA_LEN - 1)) begin
            r_step        <= '0;
            r_start_count <= 1'b0;
`ifdef MUX_SCHED_LEARN_EN
            r_state       <= S_LEARN;
            r_learn_en    <= 1'b1;
            r_lcnt        <= '0;
`else
            r_state       <= S_GRST;
            r_grst        <= 1'b1;
            r_gcnt        <= '0;
            r_done        <= (GRST_CYCLES == 1);
`endif
          end else begin
            r_step <= r_step + 1'b1;
          end
        end
`ifdef MUX_SCHED_LEARN_EN
        S_LEARN: begin
          if (r_lcnt == LC_W'(LEARN_CYCLES - 1)) begin
            r_state    <= S_GRST;
            r_learn_en <= 1'b0;
            r_grst     <= 1'b1;
            r_gcnt     <= '0;
            r_done     <= (GRST_CYCLES == 1);
          end else begin
            r_lcnt <= r_lcnt + 1'b1;
          end
        end
`endif
        S_GRST: begin
          if (r_gcnt == GC_W'(GRST_CYCLES - 1)) begin
            r_state     <= S_IDLE;
            r_grst      <= 1'b0;
            r_done      <= 1'b0;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_busy      <= 1'b0;
          end else begin
            r_gcnt <= r_gcnt + 1'b1;
            // done lands on the final grst cycle, while grant is still held
            r_done <= (int'(r_gcnt) == GRST_CYCLES - 2);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_idx   = r_grant_idx;
  assign o_col_load    = r_col_load;
  assign o_start_count = r_start_count;
  assign o_step        = r_step;
  assign o_grst        = r_grst;
  assign o_done        = r_done;
  assign o_busy        = r_busy;
`ifdef MUX_SCHED_LEARN_EN
  assign o_learn_en    = r_learn_en;
`endif

endmodule

// File: doc/mux_column_scheduler.md
Name: mux_column_scheduler

Overview:
- Time-multiplexes one physical macro column among NUM_COLS virtual columns.
- Each virtual column gets the physical column for one complete gamma cycle.
- Round-robin arbitration over requesters; sequences the weight/state load, the unary time-step count window, and the gamma-reset (grst) pulse.
- Sits between the virtual-column input buffers and the shared column datapath; drives its mux selects, start_count and grst.

Parameters:
- NUM_COLS, 4: number of virtual columns sharing the physical column (≥2).
- GAMMA_LEN, 8: time steps per gamma cycle (≥2).
- GRST_CYCLES, 2: width of the grst pulse in clk cycles (≥1).
- IDX_W, $clog2(NUM_COLS): width of grant_idx.
- STEP_W, $clog2(GAMMA_LEN): width of step.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  scheduler enable; sampled only in IDLE.
- req  in  NUM_COLS  per-virtual-column request (level).
- grant  out  NUM_COLS  one-hot owner of the physical column; 0 when none.
- grant_idx  out  IDX_W  binary index of the owner.
- col_load  out  1  one-cycle strobe: load the owner's weights/state into the column.
- start_count  out  1  high during the RUN window only.
- step  out  STEP_W  current time step within the gamma cycle.
- grst  out  1  gamma reset to the column datapath.
- done  out  1  one-cycle completion strobe, qualified by grant/grant_idx.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=0, async): state=IDLE.
  - grant=0, grant_idx=0, col_load=0, start_count=0, step=0, grst=0, done=0, busy=0.
  - Round-robin pointer=NUM_COLS-1, so the first search starts at index 0.
- FSM states: IDLE, LOAD, RUN, GRST.
- IDLE:
  - If en && |req: pick the first requester searching from pointer+1 with wrap-around.
  - Register grant/grant_idx, set pointer=winner, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD: exactly 1 cycle. col_load=1, busy=1, grant held. Next state RUN, step=0.
- RUN: exactly GAMMA_LEN cycles.
  - start_count=1; step counts 0..GAMMA_LEN-1, incrementing each cycle.
  - On step==GAMMA_LEN-1: go to GRST, step returns to 0.
- GRST: exactly GRST_CYCLES cycles with grst=1.
  - done=1 on the last GRST cycle, while grant is still valid.
  - Next state IDLE; grant and grant_idx clear to 0 on entry to IDLE.
- Latency: req seen in IDLE -> col_load 1 cycle later.
- Gamma slot length: 1 (IDLE) + 1 + GAMMA_LEN + GRST_CYCLES cycles, i.e. 12 at defaults.
- All outputs are registered (Moore); no combinational path from req or en to any output.
- Boundary conditions:
  - Owner deasserts req mid-slot: slot runs to completion, done still fires.
  - en deasserted mid-slot: current slot completes; no new grant while en=0.
  - Only one requester: it is re-granted every slot.
  - All requesters active: strict rotation 0,1,…,NUM_COLS-1,0.
  - Pointer wraps from NUM_COLS-1 to 0.
  - New req arriving outside IDLE: waits for the next IDLE; no preemption.
  - rst_n asserted in any state: immediate return to reset values, including grst=0 (a grst pulse is aborted).
  - step never reaches GAMMA_LEN.
  - grant is always one-hot or zero.

Optional Feature:
- Macro MUX_SCHED_LEARN_EN.
- When defined:
  - Adds parameter LEARN_CYCLES (default 2) and output learn_en (1 bit, reset 0).
  - Adds state LEARN between RUN and GRST, lasting LEARN_CYCLES cycles with learn_en=1 and start_count=0.
  - grant held through LEARN; slot length grows by LEARN_CYCLES.
- When undefined: no learn_en port, no LEARN state; RUN goes directly to GRST.

Test Plan:
- Reset check: hold rst_n=0 with req=4'b1111, en=1 -> all outputs 0; on release, first grant=4'b0001 after 1 cycle in IDLE, col_load high 1 cycle.
- Single slot timing: req=4'b0100 steady, defaults -> col_load 1 cycle; start_count 8 cycles with step 0..7; grst 2 cycles; done on 2nd grst cycle with grant_idx=2; IDLE; next col_load exactly 12 cycles after the first.
- Round-robin fairness: req=4'b1111 for 8 slots -> grant_idx sequence 0,1,2,3,0,1,2,3; exactly one done per slot.
- Sparse/wrap: req=4'b1001 -> sequence 0,3,0,3; indices 1 and 2 never granted.
- Mid-slot events:
  - Owner drops req at step 3 -> slot finishes, done fires.
  - en=0 at step 5 -> slot finishes, then stays IDLE with busy=0 until en=1.
- Async reset mid-grst: assert rst_n=0 during the 1st grst cycle -> grst, grant, busy drop without waiting for clk; after release, arbitration restarts from index 0.
- With MUX_SCHED_LEARN_EN defined: slot length is 14 cycles; learn_en high exactly 2 cycles between the step==7 cycle and the first grst cycle.
